// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: exhaustive stimulus sequencer for a small combinational
// gate under test. Steps a drive vector through every input combination,
// holds each one for DWELL cycles, samples the gate output into a truth
// table and compares that table against EXPECTED.
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous, active-high reset (priority over start)
//   i_start      sweep request, sampled only while idle
//   i_gate_z     output of the gate under test (combinational from o_x)
//   o_x          drive vector; o_x[N_IN-1] feeds gate input x0
//   o_busy       high from sweep accept until the done cycle ends
//   o_done       one-cycle pulse at sweep end
//   o_table      captured truth table, bit i = gate_z while x == i
//   o_pass       captured table equals EXPECTED (valid from done)
//   o_err_valid  at least one mismatch seen in the current or last sweep
//   o_err_idx    index of the first mismatch, 0 when o_err_valid = 0
//
// Build option: define GATE_SWEEP_LOOP_EN to make the sequencer restart
// a new sweep straight after each done cycle; only reset stops it.

module gate_sweep_ctrl #(
    parameter int                 N_IN     = 3,
    parameter int                 DWELL    = 4,
    parameter logic [2**N_IN-1:0] EXPECTED = 8'hFE
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_gate_z,
    output logic [N_IN-1:0]      o_x,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_table,
    output logic                 o_pass,
    output logic                 o_err_valid,
    output logic [N_IN-1:0]      o_err_idx
);

    localparam int NV = 2**N_IN;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(DWELL - 1);
    localparam logic [N_IN-1:0] X_LAST   = N_IN'(NV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state;

    logic [N_IN-1:0]   r_x;
    logic [CW-1:0]     r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [NV-1:0]     r_table;
    logic              r_pass;
    logic              r_err_valid;
    logic [N_IN-1:0]   r_err_idx;

    logic [N_IN-1:0]   w_x;
    logic [CW-1:0]     w_cnt;
    logic              w_busy;
    logic              w_done;
    logic [NV-1:0]     w_table;
    logic              w_pass;
    logic              w_err_valid;
    logic [N_IN-1:0]   w_err_idx;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next-state and next-output logic. Every output is registered, so
    // o_done is raised on the transition into S_DONE and is high for
    // exactly the cycle spent there.
    always_comb begin
        w_state     = r_state;
        w_x         = r_x;
        w_cnt       = r_cnt;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_table     = r_table;
        w_pass      = r_pass;
        w_err_valid = r_err_valid;
        w_err_idx   = r_err_idx;

        unique case (r_state)
            S_IDLE: begin
                w_x    = '0;
                w_busy = 1'b0;
                if (i_start) begin
                    w_state     = S_DRIVE;
                    w_busy      = 1'b1;
                    w_cnt       = CNT_LOAD;
                    w_table     = '0;
                    w_pass      = 1'b0;
                    w_err_valid = 1'b0;
                    w_err_idx   = '0;
                end
            end

            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_state = S_SAMPLE;
                end else begin
                    w_cnt = r_cnt - 1'b1;
                end
            end

            S_SAMPLE: begin
                w_table[r_x] = i_gate_z;
                // Only the first mismatch of a sweep is recorded
                if ((i_gate_z != EXPECTED[r_x]) && !r_err_valid) begin
                    w_err_valid = 1'b1;
                    w_err_idx   = r_x;
                end
                if (r_x == X_LAST) begin
                    w_state = S_DONE;
                    w_done  = 1'b1;
                    // Compare with the final bit merged in so that
                    // o_pass is already valid during the done cycle
                    w_pass  = (w_table == EXPECTED);
                end else begin
                    w_state = S_DRIVE;
                    w_x     = r_x + 1'b1;
                    w_cnt   = CNT_LOAD;
                end
            end

            S_DONE: begin
`ifdef GATE_SWEEP_LOOP_EN
                w_state     = S_DRIVE;
                w_busy      = 1'b1;
                w_x         = '0;
                w_cnt       = CNT_LOAD;
                w_table     = '0;
                w_err_valid = 1'b0;
                w_err_idx   = '0;
`else
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_x     = '0;
`endif
            end

            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_x     = '0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x         <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_table     <= '0;
            r_pass      <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_idx   <= '0;
        end else begin
            r_x         <= w_x;
            r_cnt       <= w_cnt;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_table     <= w_table;
            r_pass      <= w_pass;
            r_err_valid <= w_err_valid;
            r_err_idx   <= w_err_idx;
        end
    end

    assign o_x         = r_x;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_table     = r_table;
    assign o_pass      = r_pass;
    assign o_err_valid = r_err_valid;
    assign o_err_idx   = r_err_idx;

endmodule
